// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - opt field positions and access-size encodings
//   - FSM state enum
//   - bytes_of(): access size in bytes
package lsu_pkg;

    localparam int unsigned OPT_W        = 4;
    localparam int unsigned OPT_STORE    = 0;
    localparam int unsigned OPT_SIZE_LSB = 1;
    localparam int unsigned OPT_UNSIGNED = 3;
    localparam int unsigned SIZE_W       = 2;

    localparam logic [SIZE_W-1:0] LSU_SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] LSU_SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] LSU_SZ_W = 2'd2;
    localparam logic [SIZE_W-1:0] LSU_SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic int unsigned bytes_of(input logic [SIZE_W-1:0] size);
        return 32'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU (purely combinational).
//   off, size, is_unsigned : access offset within the word, size, load extension mode
//   wdata -> wdata_sh, wstrb : store data moved to its byte lane plus byte enables
//   rdata -> rdata_ext       : load data shifted down, truncated and extended
//   misalign                 : offset not a multiple of the size, or D on a 32-bit unit
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [SIZE_W-1:0]         size,
    input  logic                      is_unsigned,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           wdata_sh,
    output logic [XLEN/8-1:0]         wstrb,
    output logic [XLEN-1:0]           rdata_ext,
    output logic                      misalign
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned BOFF_W = $clog2(XLEN);
    localparam bit          D_OK   = (XLEN == 64);

    logic [BOFF_W-1:0] bit_off;
    logic [STRB_W:0]   size_mask;
    logic [OFF_W-1:0]  low_mask;
    logic [XLEN-1:0]   rshift;

    assign bit_off  = {off, 3'b000};

    // One extra bit so a full-width access (1 << STRB_W) - 1 still fits.
    assign size_mask = ((STRB_W+1)'(1) << bytes_of(size)) - (STRB_W+1)'(1);
    assign wstrb     = STRB_W'(size_mask << off);
    assign wdata_sh  = wdata << bit_off;

    assign low_mask  = OFF_W'(bytes_of(size) - 32'd1);
    assign misalign  = ((off & low_mask) != '0) || (!D_OK && (size == LSU_SZ_D));

    assign rshift    = rdata >> bit_off;

    // Truncate to the access size, then sign- or zero-extend.
    always_comb begin
        rdata_ext = rshift;
        case (size)
            LSU_SZ_B: rdata_ext = is_unsigned ? XLEN'(rshift[7:0])  : XLEN'($signed(rshift[7:0]));
            LSU_SZ_H: rdata_ext = is_unsigned ? XLEN'(rshift[15:0]) : XLEN'($signed(rshift[15:0]));
            LSU_SZ_W: rdata_ext = is_unsigned ? XLEN'(rshift[31:0]) : XLEN'($signed(rshift[31:0]));
            default:  rdata_ext = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Multi-cycle load/store unit between the EXU and a req/gnt/rvalid data-memory port.
//   EXU side : i_valid/o_ready accept, i_opt/i_addr/i_wdata request,
//              o_valid pulse with o_rdata and o_misalign
//   Mem side : o_mem_req/we/addr/wdata/wstrb held from registers until i_mem_gnt,
//              load data returned on i_mem_rvalid/i_mem_rdata
//   i_clk, i_rst (asynchronous, active-high)
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [OPT_W-1:0]    i_opt,
    input  logic [XLEN-1:0]     i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic                o_valid,
    output logic [XLEN-1:0]     o_rdata,
    output logic                o_misalign,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [XLEN-1:0]     o_mem_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_wstrb,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata
);

    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    lsu_state_e        state;
    lsu_state_e        state_nxt;
    logic [OPT_W-1:0]  opt_q;
    logic [OFF_W-1:0]  off_q;
    logic              accept;
    logic              is_store_in;

    logic [OFF_W-1:0]  al_off;
    logic [SIZE_W-1:0] al_size;
    logic              al_uns;
    logic [XLEN-1:0]   al_wdata_sh;
    logic [STRB_W-1:0] al_wstrb;
    logic [XLEN-1:0]   al_rdata_ext;
    logic              al_misalign;

    assign accept      = i_valid && (state == IDLE);
    assign is_store_in = i_opt[OPT_STORE];

    // In IDLE the aligner sees the incoming request; afterwards the latched one for load return.
    assign al_off  = (state == IDLE) ? i_addr[OFF_W-1:0] : off_q;
    assign al_size = (state == IDLE) ? i_opt[OPT_SIZE_LSB +: SIZE_W] : opt_q[OPT_SIZE_LSB +: SIZE_W];
    assign al_uns  = (state == IDLE) ? i_opt[OPT_UNSIGNED] : opt_q[OPT_UNSIGNED];

    lsu_align #(.XLEN(XLEN)) u_align (
        .off         (al_off),
        .size        (al_size),
        .is_unsigned (al_uns),
        .wdata       (i_wdata),
        .rdata       (i_mem_rdata),
        .wdata_sh    (al_wdata_sh),
        .wstrb       (al_wstrb),
        .rdata_ext   (al_rdata_ext),
        .misalign    (al_misalign)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid)      state_nxt = al_misalign ? RESP : REQ;
            REQ:     if (i_mem_gnt)    state_nxt = opt_q[OPT_STORE] ? RESP : WAIT_R;
            WAIT_R:  if (i_mem_rvalid) state_nxt = RESP;
            RESP:                      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        o_ready   = 1'b0;
        o_mem_req = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE:    o_ready   = 1'b1;
            REQ:     o_mem_req = 1'b1;
            RESP:    o_valid   = 1'b1;
            default: ;
        endcase
    end

    // Request and response registers; the memory bus is only loaded for aligned accesses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            opt_q       <= '0;
            off_q       <= '0;
            o_misalign  <= 1'b0;
            o_rdata     <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
        end else begin
            if (accept) begin
                opt_q      <= i_opt;
                off_q      <= i_addr[OFF_W-1:0];
                o_misalign <= al_misalign;
                o_rdata    <= '0;
                if (!al_misalign) begin
                    o_mem_we    <= is_store_in;
                    o_mem_addr  <= i_addr & ~XLEN'(STRB_W - 1);
                    o_mem_wdata <= is_store_in ? al_wdata_sh : '0;
                    o_mem_wstrb <= is_store_in ? al_wstrb : '0;
                end else begin
                    o_mem_we    <= 1'b0;
                    o_mem_wstrb <= '0;
                end
            end
            if ((state == WAIT_R) && i_mem_rvalid) begin
                o_rdata <= al_rdata_ext;
            end
        end
    end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Parametrised load/store unit sitting between the EXU and the data-memory port. It accepts one memory operation per handshake, checks alignment and drives a request/grant/response memory bus with byte strobes and lane-shifted data. It returns sign- or zero-extended load data to the writeback stage. It replaces the single-cycle DPI-coupled LSU with a registered, multi-cycle, stall-capable block for XLEN = 32 or 64.

## Interface
- XLEN, 32: data/address width; 32 or 64 only.
- STRB_W, XLEN/8: byte-strobe width (derived, not overridden).
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  EXU request valid.
- o_ready  out  1  LSU can accept; high only in IDLE.
- i_opt  in  4  operation, encoding below.
- i_addr  in  XLEN  byte address (EXU result).
- i_wdata  in  XLEN  store data, right-aligned.
- o_valid  out  1  one-cycle completion pulse; no backpressure.
- o_rdata  out  XLEN  extended load data; 0 for stores and errors.
- o_misalign  out  1  with o_valid: access was misaligned, no memory access made.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  XLEN  i_addr with low log2(STRB_W) bits cleared.
- o_mem_wdata  out  XLEN  store data shifted to byte lane.
- o_mem_wstrb  out  STRB_W  byte enables; 0 for reads.
- i_mem_gnt  in  1  memory accepted request this cycle.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  XLEN  full aligned word.

## Operation
- i_opt: bit0 store; bits[2:1] size (0 B, 1 H, 2 W, 3 D); bit3 unsigned (loads only; ignored for stores).
- Size D with XLEN = 32 is illegal: reported as o_misalign.
- Alignment: H needs addr[0] = 0; W needs addr[1:0] = 0; D needs addr[2:0] = 0. B is always aligned.
- Byte offset off = addr[log2(STRB_W)-1:0].
- wstrb = ((1<<bytes)-1) << off.
- wdata = i_wdata << (8*off).
- Load result = (rdata >> 8*off), truncated to the access size, then sign-extended (bit3 = 0) or zero-extended (bit3 = 1).
- FSM:
  - IDLE: o_ready = 1. On i_valid: latch opt/addr/wdata. If misaligned → RESP; otherwise → REQ.
  - REQ: o_mem_req = 1, all o_mem_* held stable from registers. On i_mem_gnt: store → RESP, load → WAIT_R.
  - WAIT_R: on i_mem_rvalid, capture and extend data into the o_rdata register → RESP.
  - RESP: o_valid = 1 for exactly one cycle → IDLE.
- i_mem_rvalid outside WAIT_R is ignored. i_mem_rvalid in the grant cycle is ignored; memory must respond at least one cycle after grant.
- The request is never withdrawn before grant.

## Timing
- Reset: state IDLE. o_ready = 1. o_valid, o_misalign, o_mem_req, o_mem_we, o_mem_wstrb = 0. o_rdata, o_mem_addr, o_mem_wdata = 0.
- All outputs are registered or decoded from state; there is no combinational path from any input to any output.
- Accept in cycle 0 (i_valid & o_ready).
  - Store with immediate grant: o_mem_req in cycle 1, o_valid in cycle 2.
  - Load with grant in cycle 1 and rvalid in cycle 2: o_valid in cycle 3.
  - Misaligned: o_valid + o_misalign in cycle 1, no o_mem_req.
- Each grant-wait cycle or rvalid-wait cycle adds one cycle of latency.
- Back-to-back: the next accept occurs in the cycle after RESP (o_ready is low during RESP).
- Asserting i_rst mid-operation returns the block to IDLE and drops o_mem_req immediately. A pending memory response after reset is ignored.

## Structure
- Package lsu_pkg:
  - opt field positions and size constants (LSU_SZ_B/H/W/D);
  - state enum (IDLE, REQ, WAIT_R, RESP);
  - function bytes_of(size).
- Sub-module lsu_align (combinational), used on both the store and load paths:
  - store side: off + size + data → shifted wdata, wstrb;
  - load side: off + size + unsigned + rdata → extended result;
  - also computes misalign.
- The top module holds the FSM and request registers.

## Test plan
- XLEN = 32, SB addr 0x1003, wdata 0x000000A5, gnt immediately → mem addr 0x1000, wstrb 4'b1000, wdata 0xA5000000; o_valid in cycle 2, o_rdata 0.
- XLEN = 32, LH addr 0x2002, rdata 0x80FF1234, gnt after 2 wait cycles, rvalid 1 cycle later → o_rdata 0xFFFF80FF. The same access with LHU → 0x000080FF.
- XLEN = 64, LW addr 0x3004, rdata 0x89ABCDEF_01234567 → o_rdata 0xFFFFFFFF89ABCDEF. SD addr 0x3000 → wstrb 8'hFF.
- LW addr 0x4002 (misaligned) → no o_mem_req; o_valid + o_misalign in cycle 1; o_rdata 0. SD (size D) with XLEN = 32 → same response.
- Load issued, i_rst pulsed while in WAIT_R, then rvalid arrives → no o_valid; all outputs at reset values; a new request is accepted normally afterwards.
- Stray rvalid while in IDLE/REQ → ignored. Two back-to-back stores → second accept in the cycle after the first o_valid.
